// File: rtl/gf_alu_seq_pkg.sv
// Shared types and elaboration helpers for the digit-serial gated-ALU sequencer.
package gf_alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic cmpl_x;
    logic cmpl_y;
    logic op_and;
    logic op_xor;
    logic op_arith;
  } op_ctrl_t;

  typedef struct packed {
    logic [1:0] xin;
    logic [1:0] yin;
    logic       carry_in;
    logic       end_bar;
    op_ctrl_t   ctrl;
  } alu_drive_t;

  function automatic int ndig(input int width);
    return width / 2;
  endfunction

  function automatic int timer_w(input int alu_lat);
    return (alu_lat < 1) ? 1 : $clog2(alu_lat + 1);
  endfunction

  function automatic bit width_ok(input int width);
    return (width >= 2) && ((width % 2) == 0);
  endfunction

endpackage

// File: rtl/gf_alu_seq_timer.sv
// Loadable up-counter that flags when it reaches the ALU pipeline latency.
module gf_alu_seq_timer
  import gf_alu_seq_pkg::*;
#(
  parameter int LAT = 7,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         inc_i,
  input  logic [W-1:0] load_val_i,
  output logic         term_o
);

  localparam logic [W-1:0] TERM = W'(LAT);

  logic [W-1:0] count_q, count_d;

  assign term_o = (count_q == TERM);

  // Counting stops at the terminal value so the flag stays stable until reload.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i && !term_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gf_alu_digit_seq.sv
// Digit-serial sequencer: issues 2-bit digits LSB first to a pipelined gated ALU
// slice, chains its carry back in, and assembles the full-width result and flags.
module gf_alu_digit_seq
  import gf_alu_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic             cmpl_x,
  input  logic             cmpl_y,
  input  logic             op_and,
  input  logic             op_xor,
  input  logic             op_arith,
  input  logic             carry_in_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_final,
  output logic             overflow_final,
  output logic [1:0]       alu_xin,
  output logic [1:0]       alu_yin,
  output logic             alu_carry_in,
  output logic             alu_end_bar,
  output logic             alu_cmpl_x,
  output logic             alu_cmpl_y,
  output logic             alu_op_and,
  output logic             alu_op_xor,
  output logic             alu_op_arith,
  input  logic [1:0]       alu_zout,
  input  logic             alu_carry_out,
  input  logic             alu_overflow
);

  localparam int NDIG = ndig(WIDTH);
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int TW   = timer_w(ALU_LAT);
  localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("gf_alu_digit_seq: WIDTH must be even and at least 2");
  end

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  op_ctrl_t         ctrl_q, ctrl_d;
  logic             cin0_q, cin0_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cfin_q, cfin_d;
  logic             ofin_q, ofin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  alu_drive_t       alu_q, alu_d;
  logic             capture, sample, tmr_term;

  gf_alu_seq_timer #(
    .LAT (ALU_LAT),
    .W   (TW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == ISSUE),
    .inc_i      (state_q == WAIT),
    .load_val_i (TW'(1)),
    .term_o     (tmr_term)
  );

  // NOTE: every _d variable gets its default before any branch, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    capture = 1'b0;
    sample  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          k_d     = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (tmr_term) begin
          sample = 1'b1;
          if (k_q == K_LAST) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    x_d    = capture ? x_in : x_q;
    y_d    = capture ? y_in : y_q;
    cin0_d = capture ? carry_in_init : cin0_q;
    ctrl_d = ctrl_q;
    if (capture) begin
      ctrl_d = {cmpl_x, cmpl_y, op_and, op_xor, op_arith};
    end

    carry_d  = carry_q;
    result_d = result_q;
    cfin_d   = cfin_q;
    ofin_d   = ofin_q;
    if (capture) begin
      carry_d  = 1'b0;
      result_d = '0;
      cfin_d   = 1'b0;
      ofin_d   = 1'b0;
    end else if (sample) begin
      carry_d                      = alu_carry_out;
      result_d[{k_q, 1'b0} +: 2]   = alu_zout;
      if (k_q == K_LAST) begin
        cfin_d = alu_carry_out;
        ofin_d = alu_overflow;
      end
    end

    // ALU drive is built from next-state values so it is registered yet lines up with ISSUE.
    alu_d = '0;
    if (state_d == ISSUE) begin
      alu_d.xin      = x_d[{k_d, 1'b0} +: 2];
      alu_d.yin      = y_d[{k_d, 1'b0} +: 2];
      alu_d.carry_in = (k_d == '0) ? cin0_d : carry_d;
      alu_d.end_bar  = (k_d != K_LAST);
      alu_d.ctrl     = ctrl_d;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      ctrl_q   <= '0;
      cin0_q   <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cfin_q   <= 1'b0;
      ofin_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      alu_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ctrl_q   <= ctrl_d;
      cin0_q   <= cin0_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cfin_q   <= cfin_d;
      ofin_q   <= ofin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      alu_q    <= alu_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign result         = result_q;
  assign carry_final    = cfin_q;
  assign overflow_final = ofin_q;
  assign alu_xin        = alu_q.xin;
  assign alu_yin        = alu_q.yin;
  assign alu_carry_in   = alu_q.carry_in;
  assign alu_end_bar    = alu_q.end_bar;
  assign alu_cmpl_x     = alu_q.ctrl.cmpl_x;
  assign alu_cmpl_y     = alu_q.ctrl.cmpl_y;
  assign alu_op_and     = alu_q.ctrl.op_and;
  assign alu_op_xor     = alu_q.ctrl.op_xor;
  assign alu_op_arith   = alu_q.ctrl.op_arith;

endmodule

// File: tb/tb_gf_alu_digit_seq.sv
// Self-checking bench: behavioural 2-bit ALU with fixed latency around the sequencer,
// full-width arithmetic reference, vector table plus random operations and corner sequences.
module tb_gf_alu_digit_seq;

  localparam int WIDTH   = 8;
  localparam int ALU_LAT = 7;
  localparam int NDIG    = WIDTH / 2;
  localparam int PERIOD  = ALU_LAT + 1;
  localparam int DONE_AT = NDIG * PERIOD + 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] x_in, y_in;
  logic             cmpl_x, cmpl_y, op_and, op_xor, op_arith, carry_in_init;
  logic             busy, done;
  logic [WIDTH-1:0] result;
  logic             carry_final, overflow_final;
  logic [1:0]       alu_xin, alu_yin;
  logic             alu_carry_in, alu_end_bar, alu_cmpl_x, alu_cmpl_y;
  logic             alu_op_and, alu_op_xor, alu_op_arith;
  logic [1:0]       alu_zout;
  logic             alu_carry_out, alu_overflow;

  int checks = 0;
  int errors = 0;

  gf_alu_digit_seq #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .x_in           (x_in),
    .y_in           (y_in),
    .cmpl_x         (cmpl_x),
    .cmpl_y         (cmpl_y),
    .op_and         (op_and),
    .op_xor         (op_xor),
    .op_arith       (op_arith),
    .carry_in_init  (carry_in_init),
    .busy           (busy),
    .done           (done),
    .result         (result),
    .carry_final    (carry_final),
    .overflow_final (overflow_final),
    .alu_xin        (alu_xin),
    .alu_yin        (alu_yin),
    .alu_carry_in   (alu_carry_in),
    .alu_end_bar    (alu_end_bar),
    .alu_cmpl_x     (alu_cmpl_x),
    .alu_cmpl_y     (alu_cmpl_y),
    .alu_op_and     (alu_op_and),
    .alu_op_xor     (alu_op_xor),
    .alu_op_arith   (alu_op_arith),
    .alu_zout       (alu_zout),
    .alu_carry_out  (alu_carry_out),
    .alu_overflow   (alu_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural 2-bit gated ALU with ALU_LAT latency
  typedef struct packed {
    bit [1:0] z;
    bit       co;
    bit       ov;
  } alu_res_t;

  alu_res_t pipe [ALU_LAT];

  function automatic alu_res_t alu_f(input logic [1:0] xi, input logic [1:0] yi,
                                     input logic ci, input logic eb, input logic cx,
                                     input logic cy, input logic oa, input logic ox,
                                     input logic oar);
    logic [1:0] a, b;
    logic [2:0] s;
    logic       c1;
    alu_res_t   r;
    r = '0;
    a = cx ? ~xi : xi;
    b = cy ? ~yi : yi;
    if (oar) begin
      s    = {1'b0, a} + {1'b0, b} + {2'b00, ci};
      c1   = (a[0] & b[0]) | (a[0] & ci) | (b[0] & ci);
      r.z  = s[1:0];
      r.co = s[2];
      r.ov = !eb && (c1 ^ s[2]);
    end else if (oa) begin
      r.z = a & b;
    end else if (ox) begin
      r.z = a ^ b;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= alu_f(alu_xin, alu_yin, alu_carry_in, alu_end_bar, alu_cmpl_x,
                     alu_cmpl_y, alu_op_and, alu_op_xor, alu_op_arith);
    for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign alu_zout      = pipe[ALU_LAT-1].z;
  assign alu_carry_out = pipe[ALU_LAT-1].co;
  assign alu_overflow  = pipe[ALU_LAT-1].ov;

  // ---------------- full-width reference
  typedef struct {
    logic [WIDTH-1:0] x, y;
    logic             cx, cy, o_and, o_xor, o_arith, cin;
    logic [WIDTH-1:0] er;
    logic             ec, eo;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] x, input logic [7:0] y, input logic cx,
                              input logic cy, input logic o_and, input logic o_xor,
                              input logic o_arith, input logic cin, input logic [7:0] er,
                              input logic ec, input logic eo);
    vec_t v;
    v.x = x; v.y = y; v.cx = cx; v.cy = cy;
    v.o_and = o_and; v.o_xor = o_xor; v.o_arith = o_arith; v.cin = cin;
    v.er = er; v.ec = ec; v.eo = eo;
    return v;
  endfunction

  function automatic vec_t ref_fill(input vec_t v);
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0]   s;
    vec_t r;
    r = v;
    a = v.cx ? ~v.x : v.x;
    b = v.cy ? ~v.y : v.y;
    r.ec = 1'b0;
    r.eo = 1'b0;
    if (v.o_arith) begin
      s    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, v.cin};
      r.er = s[WIDTH-1:0];
      r.ec = s[WIDTH];
      r.eo = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    end else if (v.o_and) begin
      r.er = a & b;
    end else if (v.o_xor) begin
      r.er = a ^ b;
    end else begin
      r.er = '0;
    end
    return r;
  endfunction

  // Carry into digit k: carry out of the low 2k bits of the full-width sum.
  function automatic logic exp_cin(input vec_t v, input int k);
    logic [WIDTH-1:0] ax, bx;
    int unsigned a, b, m, s;
    if (k == 0) return v.cin;
    if (!v.o_arith) return 1'b0;
    ax = v.cx ? ~v.x : v.x;
    bx = v.cy ? ~v.y : v.y;
    a = ax;
    b = bx;
    m = (32'd1 << (2 * k)) - 32'd1;
    s = (a & m) + (b & m) + v.cin;
    return ((s >> (2 * k)) & 32'd1) != 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] alu_bus();
    return {alu_xin, alu_yin, alu_carry_in, alu_end_bar, alu_cmpl_x, alu_cmpl_y,
            alu_op_and, alu_op_xor, alu_op_arith};
  endfunction

  task automatic drive_ops(input vec_t v);
    x_in = v.x; y_in = v.y;
    cmpl_x = v.cx; cmpl_y = v.cy;
    op_and = v.o_and; op_xor = v.o_xor; op_arith = v.o_arith;
    carry_in_init = v.cin;
  endtask

  task automatic scramble_inputs();
    x_in = 8'($urandom); y_in = 8'($urandom);
    cmpl_x = 1'($urandom); cmpl_y = 1'($urandom);
    op_and = 1'($urandom); op_xor = 1'($urandom); op_arith = 1'($urandom);
    carry_in_init = 1'($urandom);
  endtask

  // One operation, start presented in cycle 0; sampled at the falling edge of each cycle.
  task automatic run_op(input vec_t v, input bit disturb, input string tag);
    int   done_cyc, busy_lo;
    int   iss[$];
    logic eb[$];
    logic ci[$];
    @(negedge clk);
    check({tag, "_idle_before"}, {busy, done}, 2'b00);
    drive_ops(v);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    done_cyc = -1;
    busy_lo  = 0;
    check({tag, "_cleared"}, {result, carry_final, overflow_final}, '0);
    for (int n = 1; n <= DONE_AT + 20; n++) begin
      if (alu_op_arith || alu_op_and || alu_op_xor) begin
        iss.push_back(n);
        eb.push_back(alu_end_bar);
        ci.push_back(alu_carry_in);
      end
      if (!busy) busy_lo++;
      if (done) begin
        done_cyc = n;
        break;
      end
      scramble_inputs();
      start = disturb && (n == 5);
      @(negedge clk);
    end
    check({tag, "_done_cycle"}, done_cyc, DONE_AT);
    check({tag, "_busy_low_cycles"}, busy_lo, 0);
    check({tag, "_result"}, result, v.er);
    check({tag, "_carry_final"}, carry_final, v.ec);
    check({tag, "_overflow_final"}, overflow_final, v.eo);
    check({tag, "_issue_count"}, iss.size(), NDIG);
    for (int k = 0; k < NDIG && k < iss.size(); k++) begin
      check({tag, $sformatf("_issue_cycle%0d", k)}, iss[k], 1 + k * PERIOD);
      check({tag, $sformatf("_end_bar%0d", k)}, eb[k], (k != NDIG - 1));
      check({tag, $sformatf("_carry_in%0d", k)}, ci[k], exp_cin(v, k));
    end
    if (disturb) begin
      scramble_inputs();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_start_in_done_ignored"}, {busy, done, alu_bus()}, '0);
    end
  endtask

  vec_t tbl[11];

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   sel;
    rst = 1'b1;
    start = 1'b0;
    x_in = '0; y_in = '0;
    cmpl_x = 0; cmpl_y = 0; op_and = 0; op_xor = 0; op_arith = 0; carry_in_init = 0;

    tbl[0]  = mk(8'h5A, 8'h3C, 0, 0, 0, 0, 1, 0, 8'h96, 0, 1);
    tbl[1]  = mk(8'h10, 8'h01, 0, 1, 0, 0, 1, 1, 8'h0F, 1, 0);
    tbl[2]  = mk(8'hF0, 8'h3C, 0, 0, 1, 0, 0, 0, 8'h30, 0, 0);
    tbl[3]  = mk(8'hFF, 8'h0F, 0, 0, 0, 1, 0, 0, 8'hF0, 0, 0);
    tbl[4]  = mk(8'hFF, 8'h01, 0, 0, 0, 0, 1, 0, 8'h00, 1, 0);
    tbl[5]  = mk(8'h7F, 8'h01, 0, 0, 0, 0, 1, 0, 8'h80, 0, 1);
    tbl[6]  = mk(8'h05, 8'h03, 1, 0, 0, 0, 1, 1, 8'hFE, 0, 0);
    tbl[7]  = mk(8'hAA, 8'h0F, 1, 0, 0, 1, 0, 0, 8'h5A, 0, 0);
    tbl[8]  = mk(8'hF0, 8'h3C, 0, 1, 1, 0, 0, 0, 8'hC0, 0, 0);
    tbl[9]  = mk(8'h0F, 8'hF0, 1, 1, 0, 0, 1, 0, 8'hFF, 0, 0);
    tbl[10] = mk(8'h33, 8'h55, 0, 0, 0, 1, 0, 1, 8'h66, 0, 0);

    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, result, carry_final, overflow_final}, '0);
    check("reset_alu_bus", alu_bus(), '0);
    rst = 1'b0;

    // Table vectors run back to back: each start lands on the cycle after the previous done.
    for (int i = 0; i < 11; i++) run_op(tbl[i], 1'b0, $sformatf("vec%0d", i));

    run_op(tbl[0], 1'b1, "busy_ignore");

    // Reset in the middle of an addition, then a fresh start at cycle 20.
    @(negedge clk);
    drive_ops(tbl[0]);
    start = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 12) rst = 1'b1;
      if (n == 13) rst = 1'b0;
      if (n >= 13) begin
        check($sformatf("midrst_outputs_c%0d", n),
              {busy, done, result, carry_final, overflow_final}, '0);
        check($sformatf("midrst_alu_c%0d", n), alu_bus(), '0);
      end
    end
    run_op(tbl[1], 1'b0, "after_reset");

    // Reset and start together: reset wins and nothing is captured.
    @(negedge clk);
    drive_ops(tbl[0]);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", {busy, done}, 2'b00);
    check("rst_start_alu", alu_bus(), '0);

    for (int i = 0; i < 24; i++) begin
      v.x = 8'($urandom);
      v.y = 8'($urandom);
      v.cx = 1'($urandom);
      v.cy = 1'($urandom);
      v.cin = 1'($urandom);
      sel = $urandom_range(0, 2);
      v.o_arith = (sel == 0);
      v.o_and   = (sel == 1);
      v.o_xor   = (sel == 2);
      v = ref_fill(v);
      run_op(v, (i % 6) == 0, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
